// File: rtl/ad_meter_pkg.sv
// Shared defaults and small arithmetic helpers for the ADC amplitude meter.
// The saturating helpers work on plain 32-bit integers. Callers cast the
// result back to their own code width.
package ad_meter_pkg;

  // Default ADC code width and analogue scaling of the front end
  localparam int unsigned DEF_DW      = 12;
  localparam int unsigned DEF_VREF_MV = 5000;
  localparam int unsigned DEF_HYST    = 64;
  localparam int unsigned DEF_WIN_CYC = 50_000_000;

  // Width of the mV result and the guard bits used for the mV scaling product
  localparam int unsigned MV_W        = 16;

  // Mid-scale code for a dw-bit converter; this is the comparator's starting level
  function automatic int unsigned mid_code(input int unsigned dw);
    return 32'd1 << (dw - 32'd1);
  endfunction

  // Largest code representable in dw bits
  function automatic int unsigned full_code(input int unsigned dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

  // a + b, clamped to the top of a dw-bit code range
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned dw);
    int unsigned s;
    s = a + b;
    return (s > full_code(dw)) ? full_code(dw) : s;
  endfunction

  // a - b, clamped at code zero
  function automatic int unsigned sat_sub(input int unsigned a,
                                          input int unsigned b);
    return (a < b) ? 32'd0 : (a - b);
  endfunction

endpackage : ad_meter_pkg

// File: rtl/ad_hyst_cmp.sv
// Hysteresis comparator that squares the ADC stream for the frequency counter.
// The switching levels are thresh+HYST and thresh-HYST. Both levels clamp to
// the code range, so a threshold near either rail still gives usable bounds.
// When the last window measured too little amplitude, the output holds its
// value. This stops noise on a flat input from clocking the counter.
module ad_hyst_cmp
  import ad_meter_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned HYST = DEF_HYST
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_sample,
  input  logic          i_valid,
  input  logic [DW-1:0] i_thresh,
  input  logic          i_sig_low,
  output logic          o_f_in
);

  logic [DW-1:0] w_hi;
  logic [DW-1:0] w_lo;
  logic          w_above;
  logic          w_below;
  logic          r_f_in;

  // Upper and lower switching levels, clamped to the code range
  assign w_hi    = DW'(sat_add(32'(i_thresh), HYST, DW));
  assign w_lo    = DW'(sat_sub(32'(i_thresh), HYST));

  // The comparisons are strict. A sample exactly on a level leaves the output unchanged.
  assign w_above = (i_sample > w_hi);
  assign w_below = (i_sample < w_lo);

  // Output register: set above the upper level, clear below the lower level, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_in <= 1'b0;
    end else if (i_valid && !i_sig_low) begin
      if (w_above) begin
        r_f_in <= 1'b1;
      end else if (w_below) begin
        r_f_in <= 1'b0;
      end
    end
  end

  assign o_f_in = r_f_in;

endmodule : ad_hyst_cmp

// File: rtl/ad_vpp_meter.sv
// ADC amplitude meter and signal squarer.
// Each window of WIN_CYC clocks collects the minimum and maximum code of the
// valid samples. At the end of the window the block publishes:
//   - the two extremes,
//   - the mid-level used as the comparator threshold,
//   - a low-amplitude flag.
// One clock later it publishes the peak-to-peak amplitude in mV together
// with a one-cycle completion pulse. A window with no valid samples changes
// none of the published values.
module ad_vpp_meter
  import ad_meter_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned WIN_CYC = DEF_WIN_CYC,
  parameter int unsigned VREF_MV = DEF_VREF_MV,
  parameter int unsigned HYST    = DEF_HYST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   ad_data_in,
  input  logic            ad_valid,
  input  logic            clr,
  output logic            f_in,
  output logic [MV_W-1:0] vpp_mv,
  output logic [DW-1:0]   vmax_code,
  output logic [DW-1:0]   vmin_code,
  output logic [DW-1:0]   thresh_code,
  output logic            sig_low,
  output logic            meas_valid
);

  localparam int unsigned CW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int unsigned PW = DW + MV_W;

  localparam logic [CW-1:0] CNT_LAST   = CW'(WIN_CYC - 1);
  localparam logic [DW-1:0] LOW_LIM    = DW'(2 * HYST);
  localparam logic [DW-1:0] THRESH_RST = DW'(mid_code(DW));

  // Parameter sanity checks, evaluated at elaboration time
  if (DW < 8 || DW > 16) begin : g_bad_dw
    $error("ad_vpp_meter: DW must be within 8..16");
  end
  if (WIN_CYC < 4) begin : g_bad_win
    $error("ad_vpp_meter: WIN_CYC must be at least 4");
  end
  if (VREF_MV > 65535) begin : g_bad_vref
    $error("ad_vpp_meter: VREF_MV must fit in 16 bits");
  end
  if (HYST >= (32'd1 << (DW - 2))) begin : g_bad_hyst
    $error("ad_vpp_meter: HYST must be below 2^(DW-2)");
  end

  // Input capture stage
  logic [DW-1:0]   r_s_q;
  logic            r_v_q;

  // Window timing and running extremes
  logic [CW-1:0]   r_cnt;
  logic            r_seen;
  logic [DW-1:0]   r_cur_max;
  logic [DW-1:0]   r_cur_min;

  // Published window results
  logic [DW-1:0]   r_vmax;
  logic [DW-1:0]   r_vmin;
  logic [DW-1:0]   r_thresh;
  logic [DW-1:0]   r_vpp_code;
  logic            r_sig_low;
  logic            r_pend;
  logic [MV_W-1:0] r_vpp_mv;
  logic            r_meas_valid;

  // Combinational helpers
  logic            w_end;
  logic            w_close;
  logic [DW-1:0]   w_nmax;
  logic [DW-1:0]   w_nmin;
  logic [DW:0]     w_sum;
  logic [DW-1:0]   w_mid;
  logic [DW-1:0]   w_vpp;
  logic [PW-1:0]   w_prod;
  logic [MV_W-1:0] w_mv;

  // Register the ADC code on its strobe.
  // The strobe is delayed alongside it so the two stay aligned.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: plain pipeline/data flops are reset too; no memories exist here to exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q <= '0;
      r_v_q <= 1'b0;
    end else begin
      r_v_q <= ad_valid;
      if (ad_valid) begin
        r_s_q <= ad_data_in;
      end
    end
  end

  // This is the last cycle of the window. A window closes only if it saw at
  // least one sample, either earlier or on this cycle.
  assign w_end   = (r_cnt == CNT_LAST);
  assign w_close = w_end && (r_seen || r_v_q);

  // Extremes including the current sample.
  // The first sample of a window replaces both extremes outright.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_nmax = r_cur_max;
    w_nmin = r_cur_min;
    if (!r_seen) begin
      w_nmax = r_s_q;
      w_nmin = r_s_q;
    end else if (r_v_q) begin
      if (r_s_q > r_cur_max) begin
        w_nmax = r_s_q;
      end
      if (r_s_q < r_cur_min) begin
        w_nmin = r_s_q;
      end
    end
  end

  // The mid-level uses one extra bit so max+min cannot overflow before the halving.
  assign w_sum  = {1'b0, w_nmax} + {1'b0, w_nmin};
  assign w_mid  = DW'(w_sum >> 1);
  assign w_vpp  = w_nmax - w_nmin;

  // Scale codes to mV: (vpp * VREF_MV) / 2^DW, truncated.
  // The product is wide enough for any 16-bit reference voltage.
  assign w_prod = PW'(r_vpp_code) * PW'(VREF_MV);
  assign w_mv   = MV_W'(w_prod >> DW);

  // Window counter. It wraps every WIN_CYC clocks. A clear restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Running extremes for the current window.
  // A clear or the end of a window marks the next window as empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen    <= 1'b0;
      r_cur_max <= '0;
      r_cur_min <= '0;
    end else if (clr || w_end) begin
      r_seen    <= 1'b0;
    end else if (r_v_q) begin
      r_seen    <= 1'b1;
      r_cur_max <= w_nmax;
      r_cur_min <= w_nmin;
    end
  end

  // Publish the extremes, threshold and amplitude code when a non-empty window closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vmax     <= '0;
      r_vmin     <= '0;
      r_thresh   <= THRESH_RST;
      r_vpp_code <= '0;
      r_sig_low  <= 1'b0;
    end else if (!clr && w_close) begin
      r_vmax     <= w_nmax;
      r_vmin     <= w_nmin;
      r_thresh   <= w_mid;
      r_vpp_code <= w_vpp;
      r_sig_low  <= (w_vpp < LOW_LIM);
    end
  end

  // Flag that the mV conversion of a freshly closed window is due next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= !clr && w_close;
    end
  end

  // Deliver the mV amplitude with its completion pulse.
  // A clear arriving in between cancels both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpp_mv     <= '0;
      r_meas_valid <= 1'b0;
    end else if (clr) begin
      r_meas_valid <= 1'b0;
    end else begin
      r_meas_valid <= r_pend;
      if (r_pend) begin
        r_vpp_mv <= w_mv;
      end
    end
  end

  // Squarer for the frequency counter. It works on the same delayed sample stream.
  ad_hyst_cmp #(
    .DW   (DW),
    .HYST (HYST)
  ) u_hyst_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sample  (r_s_q),
    .i_valid   (r_v_q),
    .i_thresh  (r_thresh),
    .i_sig_low (r_sig_low),
    .o_f_in    (f_in)
  );

  assign vpp_mv      = r_vpp_mv;
  assign vmax_code   = r_vmax;
  assign vmin_code   = r_vmin;
  assign thresh_code = r_thresh;
  assign sig_low     = r_sig_low;
  assign meas_valid  = r_meas_valid;

endmodule : ad_vpp_meter

// File: tb/tb_ad_vpp_meter.sv
// Directed bench for ad_vpp_meter with DW=12, WIN_CYC=100, VREF_MV=5000, HYST=64.
// The bench drives inputs 1 time unit after each rising edge and samples the
// outputs at that same point. The expected window results are hand-computed.
// They sit in a queue keyed by the edge number at which each pulse must
// appear. Any pulse that arrives with no queued expectation is reported.
module tb_ad_vpp_meter;

  localparam int unsigned DW      = 12;
  localparam int unsigned WIN_CYC = 100;
  localparam int unsigned VREF_MV = 5000;
  localparam int unsigned HYST    = 64;

  typedef struct {
    int unsigned at_edge;
    int unsigned vmax;
    int unsigned vmin;
    int unsigned thresh;
    int unsigned mv;
    int unsigned low;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] ad_data_in;
  logic          ad_valid;
  logic          clr;
  logic          f_in;
  logic [15:0]   vpp_mv;
  logic [DW-1:0] vmax_code;
  logic [DW-1:0] vmin_code;
  logic [DW-1:0] thresh_code;
  logic          sig_low;
  logic          meas_valid;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];

  ad_vpp_meter #(
    .DW      (DW),
    .WIN_CYC (WIN_CYC),
    .VREF_MV (VREF_MV),
    .HYST    (HYST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ad_data_in  (ad_data_in),
    .ad_valid    (ad_valid),
    .clr         (clr),
    .f_in        (f_in),
    .vpp_mv      (vpp_mv),
    .vmax_code   (vmax_code),
    .vmin_code   (vmin_code),
    .thresh_code (thresh_code),
    .sig_low     (sig_low),
    .meas_valid  (meas_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic drive(input int unsigned d, input logic v);
    ad_data_in = DW'(d);
    ad_valid   = v;
  endtask

  task automatic push(input int unsigned e, input int unsigned mx, input int unsigned mn,
                      input int unsigned th, input int unsigned mv, input int unsigned lo);
    exp_t x;
    x.at_edge = e; x.vmax = mx; x.vmin = mn; x.thresh = th; x.mv = mv; x.low = lo;
    exp_q.push_back(x);
  endtask

  // Advance one clock. Every completion pulse is matched against the queued expectation.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(meas_valid), 0);
      end else begin
        x = exp_q.pop_front();
        check("pulse_edge", edge_cnt, x.at_edge);
        check("vmax_code",  vmax_code, x.vmax);
        check("vmin_code",  vmin_code, x.vmin);
        check("thresh",     thresh_code, x.thresh);
        check("vpp_mv",     vpp_mv, x.mv);
        check("sig_low",    32'(sig_low), x.low);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_f_in"},   32'(f_in), 0);
    check({tag, "_vpp_mv"}, vpp_mv, 0);
    check({tag, "_vmax"},   vmax_code, 0);
    check({tag, "_vmin"},   vmin_code, 0);
    check({tag, "_thresh"}, thresh_code, 2048);
    check({tag, "_siglow"}, 32'(sig_low), 0);
    check({tag, "_mvalid"}, 32'(meas_valid), 0);
  endtask

  // Triangle 1000 -> 3000 -> 1000 in steps of 50, period 80 samples
  function automatic int unsigned tri_val(input int k);
    int p;
    p = k % 80;
    return (p <= 40) ? 32'(1000 + 50 * p) : 32'(3000 - 50 * (p - 40));
  endfunction

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(0, 1'b0);
    repeat (3) tick();
    check_reset_state("rst");
    rst_n    = 1'b1;
    edge_cnt = 0;

    // Hysteresis around the reset threshold 2048 (levels 2112 / 1984).
    // The window then reports max 2113, min 1983, thresh 2048 and 130 codes = 158 mV.
    push(101, 2113, 1983, 2048, 158, 0);
    drive(2100, 1'b1); tick();
    drive(2113, 1'b1); tick(); check("hyst_2100", 32'(f_in), 0);
    drive(2000, 1'b1); tick(); check("hyst_2113", 32'(f_in), 1);
    drive(1983, 1'b1); tick(); check("hyst_2000", 32'(f_in), 1);
    drive(0, 1'b0);    tick(); check("hyst_1983", 32'(f_in), 0);
    while (edge_cnt < 102) tick();

    // Triangle sweep over two windows: 2000 codes = 2441 mV
    push(201, 3000, 1000, 2000, 2441, 0);
    push(301, 3000, 1000, 2000, 2441, 0);
    for (int k = 0; k < 200; k++) begin
      drive(tri_val(k), 1'b1);
      tick();
    end

    // Full scale alternating 0 / 4095: 4998 mV, threshold 2047
    push(401, 4095, 0, 2047, 4998, 0);
    while (edge_cnt < 399) begin
      drive(((edge_cnt + 1) % 2 != 0) ? 4095 : 0, 1'b1);
      tick();
    end

    // Flat 2048 for a full window: zero amplitude, low-signal flag set
    push(501, 2048, 2048, 2048, 0, 1);
    while (edge_cnt < 504) begin
      drive(2048, 1'b1);
      tick();
    end
    check("fin_after_full", 32'(f_in), 1);

    // With the low-signal flag set, rail-to-rail samples must not move f_in
    push(601, 4095, 0, 2047, 4998, 0);
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 != 0) ? 4095 : 0, 1'b1);
      tick();
      check("fin_frozen", 32'(f_in), 1);
    end

    // Empty window (captures 600..699): no pulse, everything holds
    drive(0, 1'b0);
    while (edge_cnt < 720) tick();
    check("empty_vmax",   vmax_code, 4095);
    check("empty_vmin",   vmin_code, 0);
    check("empty_thresh", thresh_code, 2047);
    check("empty_vpp_mv", vpp_mv, 4998);
    check("empty_siglow", 32'(sig_low), 0);
    check("empty_fin",    32'(f_in), 1);

    // Clear at cnt=50 after a 4000 sample; only 1500 afterwards.
    // The next pulse comes 101 edges after the clear edge (751).
    while (edge_cnt < 748) tick();
    drive(4000, 1'b1); tick();
    drive(0, 1'b0);    tick();
    clr = 1'b1;
    drive(1500, 1'b1);
    tick();
    clr = 1'b0;
    push(852, 1500, 1500, 1500, 0, 1);
    while (edge_cnt < 860) tick();

    // Asynchronous reset at cnt=70; the partial window of 3000s is discarded
    drive(3000, 1'b1);
    while (edge_cnt < 921) tick();
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    tick();
    tick();
    rst_n    = 1'b1;
    edge_cnt = 0;
    push(101, 2500, 2500, 2500, 0, 1);
    drive(2500, 1'b1);
    tick();
    tick();
    check("post_rst_fin", 32'(f_in), 1);
    while (edge_cnt < 110) tick();

    check("pulses_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ad_vpp_meter
